// File: rtl/pixel_stream_capture_if.sv
// Pixel-pair capture bus: sync/data from the sensor side plus the readback
// and status signals. The capture block takes the slave end.
interface pixel_stream_capture_if #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
);
  localparam int AW = $clog2(WIDTH * HEIGHT / 2);

  logic          VSYNC;
  logic          HSYNC;
  logic [7:0]    DATA_R0, DATA_G0, DATA_B0;
  logic [7:0]    DATA_R1, DATA_G1, DATA_B1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [47:0]   rd_data;
  logic          rd_valid;
  logic [AW:0]   pair_count;
  logic          frame_done;
  logic          line_err;
  logic          busy;

  modport master (
    output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, pair_count, frame_done, line_err, busy
  );

  modport slave (
    input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, pair_count, frame_done, line_err, busy
  );
endinterface

// File: rtl/pixel_stream_capture.sv
// Captures one frame of pixel pairs into a bottom-up (BMP row order) buffer
// and serves registered readback while no capture is in progress.
module pixel_stream_capture #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input logic                  HCLK,
  input logic                  HRESET,
  pixel_stream_capture_if.slave bus
);
  localparam int DEPTH = WIDTH * HEIGHT / 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int PAIRS = WIDTH / 2;
  localparam int PW    = $clog2(PAIRS);
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] colp_q, colp_d;
  logic [AW:0]   pc_q, pc_d;
  logic          line_err_q, line_err_d;
  logic [47:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic [47:0]   mem [DEPTH];

  logic          store_en;
  logic          line_abort;
  logic          rd_ok;
  logic          busy;
  logic          frame_done;
  logic          last_pair;
  logic          last_row;
  logic [AW-1:0] wr_addr;
  logic [47:0]   wr_word;

  assign last_pair = (colp_q == PW'(PAIRS - 1));
  assign last_row  = (row_q == RW'(HEIGHT - 1));
  assign wr_word   = {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0,
                      bus.DATA_R1, bus.DATA_G1, bus.DATA_B1};
  // Line 0 lands in the top of the buffer so word 0 is the last line's first pair.
  assign wr_addr   = AW'((HEIGHT - 1 - int'(row_q)) * PAIRS + int'(colp_q));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.VSYNC) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        ARMED, CAPTURE: begin
          if (store_en) begin
            if (last_pair) state_d = last_row ? DONE : ARMED;
            else           state_d = CAPTURE;
          end else if (line_abort) begin
            state_d = ARMED;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    store_en   = 1'b0;
    line_abort = 1'b0;
    rd_ok      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE:    rd_ok = bus.rd_en;
      ARMED: begin
        busy     = 1'b1;
        store_en = bus.HSYNC && !bus.VSYNC;
      end
      CAPTURE: begin
        busy       = 1'b1;
        store_en   = bus.HSYNC && !bus.VSYNC;
        line_abort = !bus.HSYNC && !bus.VSYNC && (colp_q != '0);
      end
      DONE: begin
        frame_done = 1'b1;
        rd_ok      = bus.rd_en;
      end
      default: ;
    endcase
  end

  always_comb begin
    row_d      = row_q;
    colp_d     = colp_q;
    pc_d       = pc_q;
    line_err_d = line_err_q;
    if (bus.VSYNC) begin
      row_d      = '0;
      colp_d     = '0;
      pc_d       = '0;
      line_err_d = 1'b0;
    end else if (store_en) begin
      pc_d = pc_q + (AW+1)'(1);
      if (last_pair) begin
        colp_d = '0;
        if (!last_row) row_d = row_q + RW'(1);
      end else begin
        colp_d = colp_q + PW'(1);
      end
    end else if (line_abort) begin
      // Partial line is simply overwritten by the retry of the same row.
      colp_d     = '0;
      line_err_d = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = rd_ok;
    rd_data_d  = rd_data_q;
    if (rd_ok) rd_data_d = (int'(bus.rd_addr) < DEPTH) ? mem[bus.rd_addr] : '0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      row_q      <= '0;
      colp_q     <= '0;
      pc_q       <= '0;
      line_err_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      colp_q     <= colp_d;
      pc_q       <= pc_d;
      line_err_q <= line_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Buffer is never reset; a same-cycle read sees the pre-write contents.
  always_ff @(posedge HCLK) begin
    if (store_en) mem[wr_addr] <= wr_word;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.pair_count = pc_q;
  assign bus.frame_done = frame_done;
  assign bus.line_err   = line_err_q;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_pixel_stream_capture.sv
// Directed bench: 4x2 frame capture, short lines, VSYNC priority, readback
// gating, async reset, plus a 6x1 instance for out-of-range readback.
module tb_pixel_stream_capture;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  localparam logic [47:0] PA = 48'h11_22_33_44_55_66;
  localparam logic [47:0] PB = 48'hA1_B2_C3_D4_E5_F6;
  localparam logic [47:0] PC = 48'h0F_1E_2D_3C_4B_5A;
  localparam logic [47:0] PD = 48'hFE_DC_BA_98_76_54;
  localparam logic [47:0] PX = 48'hDE_AD_BE_EF_00_01;
  localparam logic [47:0] PY = 48'h01_02_03_04_05_06;
  localparam logic [47:0] PZ = 48'h10_20_30_40_50_60;
  localparam logic [47:0] PP = 48'h77_66_55_44_33_22;
  localparam logic [47:0] PQ = 48'h99_88_AA_BB_CC_DD;
  localparam logic [47:0] PE = 48'h5A_5A_5A_A5_A5_A5;
  localparam logic [47:0] PF = 48'h3C_3C_3C_C3_C3_C3;
  localparam logic [47:0] PG = 48'h12_34_56_78_9A_BC;
  localparam logic [47:0] PH = 48'hCB_A9_87_65_43_21;

  pixel_stream_capture_if #(.WIDTH(4), .HEIGHT(2)) b ();
  pixel_stream_capture_if #(.WIDTH(6), .HEIGHT(1)) b6 ();

  pixel_stream_capture #(.WIDTH(4), .HEIGHT(2)) u_dut (
    .HCLK(clk), .HRESET(rst), .bus(b)
  );
  pixel_stream_capture #(.WIDTH(6), .HEIGHT(1)) u_dut6 (
    .HCLK(clk), .HRESET(rst), .bus(b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at a falling edge, let one rising edge consume them.
  task automatic step(input logic v, input logic h, input logic [47:0] px);
    b.VSYNC = v;
    b.HSYNC = h;
    {b.DATA_R0, b.DATA_G0, b.DATA_B0, b.DATA_R1, b.DATA_G1, b.DATA_B1} = px;
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    b.rd_en   = 1'b1;
    b.rd_addr = a;
    step(1'b0, 1'b0, '0);
    b.rd_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    vecs++; if (b.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", b.busy); end
    vecs++; if (b.frame_done !== 1'b0) begin errs++; $display("FAIL reset_frame_done: got %b want 0", b.frame_done); end
    vecs++; if (b.line_err !== 1'b0) begin errs++; $display("FAIL reset_line_err: got %b want 0", b.line_err); end
    vecs++; if (b.rd_valid !== 1'b0) begin errs++; $display("FAIL reset_rd_valid: got %b want 0", b.rd_valid); end
    vecs++; if (b.rd_data !== 48'h0) begin errs++; $display("FAIL reset_rd_data: got %h want 0", b.rd_data); end
    vecs++; if (b.pair_count !== 3'd0) begin errs++; $display("FAIL reset_pair_count: got %0d want 0", b.pair_count); end
    rst = 1'b0;
    step(1'b0, 1'b1, PA);
    step(1'b0, 1'b1, PB);
    vecs++; if (b.pair_count !== 3'd0) begin errs++; $display("FAIL idle_hsync_count: got %0d want 0", b.pair_count); end
    vecs++; if (b.busy !== 1'b0) begin errs++; $display("FAIL idle_hsync_busy: got %b want 0", b.busy); end
  endtask

  task automatic test_full_frame;
    repeat (3) step(1'b1, 1'b0, '0);
    vecs++; if (b.busy !== 1'b1) begin errs++; $display("FAIL armed_busy: got %b want 1", b.busy); end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PA);
    step(1'b0, 1'b1, PB);
    vecs++; if (b.pair_count !== 3'd2) begin errs++; $display("FAIL line0_count: got %0d want 2", b.pair_count); end
    vecs++; if (b.frame_done !== 1'b0) begin errs++; $display("FAIL line0_done: got %b want 0", b.frame_done); end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PC);
    step(1'b0, 1'b1, PD);
    vecs++; if (b.frame_done !== 1'b1) begin errs++; $display("FAIL frame_done: got %b want 1", b.frame_done); end
    vecs++; if (b.busy !== 1'b0) begin errs++; $display("FAIL done_busy: got %b want 0", b.busy); end
    vecs++; if (b.pair_count !== 3'd4) begin errs++; $display("FAIL frame_count: got %0d want 4", b.pair_count); end
    vecs++; if (b.line_err !== 1'b0) begin errs++; $display("FAIL frame_line_err: got %b want 0", b.line_err); end
    rd(2'd0);
    vecs++; if (b.rd_valid !== 1'b1) begin errs++; $display("FAIL rd0_valid: got %b want 1", b.rd_valid); end
    vecs++; if (b.rd_data !== PC) begin errs++; $display("FAIL rd0_data: got %h want %h", b.rd_data, PC); end
    rd(2'd1);
    vecs++; if (b.rd_data !== PD) begin errs++; $display("FAIL rd1_data: got %h want %h", b.rd_data, PD); end
    rd(2'd2);
    vecs++; if (b.rd_data !== PA) begin errs++; $display("FAIL rd2_data: got %h want %h", b.rd_data, PA); end
    rd(2'd3);
    vecs++; if (b.rd_data !== PB) begin errs++; $display("FAIL rd3_data: got %h want %h", b.rd_data, PB); end
    step(1'b0, 1'b0, '0);
    vecs++; if (b.rd_valid !== 1'b0) begin errs++; $display("FAIL rd_valid_drop: got %b want 0", b.rd_valid); end
    vecs++; if (b.rd_data !== PB) begin errs++; $display("FAIL rd_data_hold: got %h want %h", b.rd_data, PB); end
  endtask

  task automatic test_done_ignores_hsync;
    step(1'b0, 1'b1, PE);
    step(1'b0, 1'b1, PF);
    vecs++; if (b.pair_count !== 3'd4) begin errs++; $display("FAIL done_frozen_count: got %0d want 4", b.pair_count); end
    vecs++; if (b.frame_done !== 1'b1) begin errs++; $display("FAIL done_stays: got %b want 1", b.frame_done); end
    rd(2'd2);
    vecs++; if (b.rd_data !== PA) begin errs++; $display("FAIL done_no_store: got %h want %h", b.rd_data, PA); end
  endtask

  task automatic test_short_line;
    step(1'b1, 1'b0, '0);
    vecs++; if (b.frame_done !== 1'b0) begin errs++; $display("FAIL vsync_clears_done: got %b want 0", b.frame_done); end
    step(1'b0, 1'b1, PX);
    step(1'b0, 1'b0, '0);
    vecs++; if (b.line_err !== 1'b1) begin errs++; $display("FAIL short_line_err: got %b want 1", b.line_err); end
    vecs++; if (b.pair_count !== 3'd1) begin errs++; $display("FAIL short_count: got %0d want 1", b.pair_count); end
    step(1'b0, 1'b1, PY);
    step(1'b0, 1'b1, PZ);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PP);
    step(1'b0, 1'b1, PQ);
    vecs++; if (b.line_err !== 1'b1) begin errs++; $display("FAIL short_sticky: got %b want 1", b.line_err); end
    vecs++; if (b.frame_done !== 1'b1) begin errs++; $display("FAIL short_done: got %b want 1", b.frame_done); end
    vecs++; if (b.pair_count !== 3'd5) begin errs++; $display("FAIL short_total: got %0d want 5", b.pair_count); end
    rd(2'd2);
    vecs++; if (b.rd_data !== PY) begin errs++; $display("FAIL short_w2: got %h want %h", b.rd_data, PY); end
    rd(2'd3);
    vecs++; if (b.rd_data !== PZ) begin errs++; $display("FAIL short_w3: got %h want %h", b.rd_data, PZ); end
    rd(2'd0);
    vecs++; if (b.rd_data !== PP) begin errs++; $display("FAIL short_w0: got %h want %h", b.rd_data, PP); end
    rd(2'd1);
    vecs++; if (b.rd_data !== PQ) begin errs++; $display("FAIL short_w1: got %h want %h", b.rd_data, PQ); end
  endtask

  task automatic test_vsync_priority;
    step(1'b1, 1'b0, '0);
    vecs++; if (b.line_err !== 1'b0) begin errs++; $display("FAIL vsync_clears_err: got %b want 0", b.line_err); end
    step(1'b0, 1'b1, PA);
    step(1'b0, 1'b1, PB);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PC);
    vecs++; if (b.pair_count !== 3'd3) begin errs++; $display("FAIL prio_pre_count: got %0d want 3", b.pair_count); end
    step(1'b1, 1'b1, PD);
    vecs++; if (b.pair_count !== 3'd0) begin errs++; $display("FAIL prio_count: got %0d want 0", b.pair_count); end
    vecs++; if (b.busy !== 1'b1) begin errs++; $display("FAIL prio_armed: got %b want 1", b.busy); end
    vecs++; if (b.line_err !== 1'b0) begin errs++; $display("FAIL prio_line_err: got %b want 0", b.line_err); end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PE);
    b.rd_en   = 1'b1;
    b.rd_addr = 2'd1;
    step(1'b0, 1'b1, PF);
    b.rd_en   = 1'b0;
    vecs++; if (b.rd_valid !== 1'b0) begin errs++; $display("FAIL gate_rd_valid: got %b want 0", b.rd_valid); end
    vecs++; if (b.rd_data !== PQ) begin errs++; $display("FAIL gate_rd_hold: got %h want %h", b.rd_data, PQ); end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PG);
    step(1'b0, 1'b1, PH);
    vecs++; if (b.pair_count !== 3'd4) begin errs++; $display("FAIL prio_frame_count: got %0d want 4", b.pair_count); end
    rd(2'd1);
    vecs++; if (b.rd_valid !== 1'b1) begin errs++; $display("FAIL gate_done_valid: got %b want 1", b.rd_valid); end
    vecs++; if (b.rd_data !== PH) begin errs++; $display("FAIL gate_done_w1: got %h want %h", b.rd_data, PH); end
    rd(2'd2);
    vecs++; if (b.rd_data !== PE) begin errs++; $display("FAIL prio_row_reset_w2: got %h want %h", b.rd_data, PE); end
  endtask

  task automatic test_reset_midframe;
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, PX);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PA);
    vecs++; if (b.line_err !== 1'b1 || b.busy !== 1'b1 || b.pair_count !== 3'd2) begin
      errs++; $display("FAIL premid_state: got err=%b busy=%b cnt=%0d want 1 1 2", b.line_err, b.busy, b.pair_count);
    end
    #2 rst = 1'b1;
    #1;
    vecs++; if (b.busy !== 1'b0) begin errs++; $display("FAIL async_busy: got %b want 0", b.busy); end
    vecs++; if (b.pair_count !== 3'd0) begin errs++; $display("FAIL async_count: got %0d want 0", b.pair_count); end
    vecs++; if (b.line_err !== 1'b0) begin errs++; $display("FAIL async_line_err: got %b want 0", b.line_err); end
    vecs++; if (b.rd_data !== 48'h0) begin errs++; $display("FAIL async_rd_data: got %h want 0", b.rd_data); end
    vecs++; if (b.rd_valid !== 1'b0 || b.frame_done !== 1'b0) begin
      errs++; $display("FAIL async_flags: got valid=%b done=%b want 0 0", b.rd_valid, b.frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, PB);
    step(1'b0, 1'b1, PC);
    vecs++; if (b.pair_count !== 3'd0 || b.busy !== 1'b0) begin
      errs++; $display("FAIL postrst_ignore: got cnt=%0d busy=%b want 0 0", b.pair_count, b.busy);
    end
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, PA);
    step(1'b0, 1'b1, PB);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PC);
    step(1'b0, 1'b1, PD);
    vecs++; if (b.frame_done !== 1'b1) begin errs++; $display("FAIL postrst_done: got %b want 1", b.frame_done); end
    rd(2'd3);
    vecs++; if (b.rd_data !== PB) begin errs++; $display("FAIL postrst_w3: got %h want %h", b.rd_data, PB); end
  endtask

  task automatic test_out_of_range;
    b6.VSYNC = 1'b1;
    @(negedge clk);
    b6.VSYNC = 1'b0;
    b6.HSYNC = 1'b1;
    {b6.DATA_R0, b6.DATA_G0, b6.DATA_B0, b6.DATA_R1, b6.DATA_G1, b6.DATA_B1} = PG;
    @(negedge clk);
    {b6.DATA_R0, b6.DATA_G0, b6.DATA_B0, b6.DATA_R1, b6.DATA_G1, b6.DATA_B1} = PH;
    @(negedge clk);
    {b6.DATA_R0, b6.DATA_G0, b6.DATA_B0, b6.DATA_R1, b6.DATA_G1, b6.DATA_B1} = PE;
    @(negedge clk);
    b6.HSYNC = 1'b0;
    vecs++; if (b6.frame_done !== 1'b1) begin errs++; $display("FAIL w6_done: got %b want 1", b6.frame_done); end
    vecs++; if (b6.pair_count !== 3'd3) begin errs++; $display("FAIL w6_count: got %0d want 3", b6.pair_count); end
    b6.rd_en   = 1'b1;
    b6.rd_addr = 2'd2;
    @(negedge clk);
    vecs++; if (b6.rd_data !== PE) begin errs++; $display("FAIL w6_w2: got %h want %h", b6.rd_data, PE); end
    b6.rd_addr = 2'd3;
    @(negedge clk);
    vecs++; if (b6.rd_valid !== 1'b1) begin errs++; $display("FAIL oor_valid: got %b want 1", b6.rd_valid); end
    vecs++; if (b6.rd_data !== 48'h0) begin errs++; $display("FAIL oor_data: got %h want 0", b6.rd_data); end
    b6.rd_addr = 2'd0;
    @(negedge clk);
    b6.rd_en = 1'b0;
    vecs++; if (b6.rd_data !== PG) begin errs++; $display("FAIL w6_w0: got %h want %h", b6.rd_data, PG); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    b.VSYNC = 1'b0; b.HSYNC = 1'b0; b.rd_en = 1'b0; b.rd_addr = '0;
    {b.DATA_R0, b.DATA_G0, b.DATA_B0, b.DATA_R1, b.DATA_G1, b.DATA_B1} = '0;
    b6.VSYNC = 1'b0; b6.HSYNC = 1'b0; b6.rd_en = 1'b0; b6.rd_addr = '0;
    {b6.DATA_R0, b6.DATA_G0, b6.DATA_B0, b6.DATA_R1, b6.DATA_G1, b6.DATA_B1} = '0;
    test_reset();
    test_full_frame();
    test_done_ignores_hsync();
    test_short_line();
    test_vsync_priority();
    test_reset_midframe();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
